// File: rtl/vram_arbiter_pkg.sv
// Shared types for the video RAM arbiter: host FSM states and read-return tags.
package zed_vram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RDPEND,
        ACK
    } host_state_e;

    typedef struct packed {
        logic valid;
        logic is_vid;
    } rd_tag_t;

endpackage

// File: rtl/vram_arbiter_if.sv
// Requester-side bus of the arbiter: video fetch port and host (CPU) port.
interface vram_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
);
    logic              vid_req;
    logic [ADDR_W-1:0] vid_addr;
    logic              vid_rvalid;
    logic [DATA_W-1:0] vid_rdata;

    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  vid_rvalid, vid_rdata, cpu_ack, cpu_rdata
    );

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output vid_rvalid, vid_rdata, cpu_ack, cpu_rdata
    );
endinterface

// File: rtl/vram_arbiter_rd_tag_pipe.sv
// Fixed-depth shift register of read tags; the output stage is valid one cycle
// before the matching memory data so the return can be registered in time.
module rd_tag_pipe
    import zed_vram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    i_clk,
    input  logic    i_flush,
    input  rd_tag_t i_tag,
    output rd_tag_t o_tag
);

    rd_tag_t r_stage [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_flush) begin
            // NOTE: unlike a data RAM, every stage is cleared: a stale valid bit would fake a return.
            for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
        end else begin
            r_stage[0] <= i_tag;
            for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
        end
    end

    assign o_tag = r_stage[DEPTH-1];

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetches win every cycle, the host uses idle
// cycles; read data is routed back by tag and the worst host wait is recorded.
module vram_arbiter
    import zed_vram_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1,
    parameter int WAIT_W = 8
) (
    input  logic              i_sys_clk,
    input  logic              i_act_reset,
    input  logic              i_mline_hdisp,
    vram_arbiter_if.slave     bus,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [WAIT_W-1:0] o_wait_max,
    input  logic              i_wait_clr
);

    localparam logic [WAIT_W-1:0] WAIT_SAT = {WAIT_W{1'b1}};

    host_state_e       r_state, w_state_next;
    rd_tag_t           w_tag_in, w_tag_out;
    logic              w_vid_grant, w_cpu_grant, w_cpu_ack;
    logic              r_vid_rvalid, r_cpu_ret;
    logic [DATA_W-1:0] r_cpu_rdata;
    logic [WAIT_W-1:0] r_wait_cnt, r_wait_max;

    // Display-phase flag does not influence priority; kept only as a status input.
    logic w_unused_hdisp;
    assign w_unused_hdisp = i_mline_hdisp;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_vid_grant  = bus.vid_req;
        w_cpu_grant  = !bus.vid_req && (r_state == WAIT);
        w_tag_in     = '{valid: w_vid_grant || (w_cpu_grant && !bus.cpu_we), is_vid: w_vid_grant};
        w_cpu_ack    = (r_state == ACK);
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.cpu_req) w_state_next = WAIT;
            WAIT:    if (w_cpu_grant) w_state_next = bus.cpu_we ? ACK : RDPEND;
            RDPEND:  if (w_tag_out.valid && !w_tag_out.is_vid) w_state_next = ACK;
            ACK:     w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_act_reset) r_state <= IDLE;
        else             r_state <= w_state_next;
    end

    // Registered memory port; address and write data hold on idle cycles.
    always_ff @(posedge i_sys_clk) begin
        if (i_act_reset) begin
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
        end else begin
            o_mem_en <= w_vid_grant || w_cpu_grant;
            o_mem_we <= w_cpu_grant && bus.cpu_we;
            if (w_vid_grant) begin
                o_mem_addr <= bus.vid_addr;
            end else if (w_cpu_grant) begin
                o_mem_addr  <= bus.cpu_addr;
                o_mem_wdata <= bus.cpu_wdata;
            end
        end
    end

    rd_tag_pipe #(.DEPTH(RD_LAT)) u_tag_pipe (
        .i_clk   (i_sys_clk),
        .i_flush (i_act_reset),
        .i_tag   (w_tag_in),
        .o_tag   (w_tag_out)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_act_reset) begin
            r_vid_rvalid <= 1'b0;
            r_cpu_ret    <= 1'b0;
            r_cpu_rdata  <= '0;
        end else begin
            r_vid_rvalid <= w_tag_out.valid && w_tag_out.is_vid;
            r_cpu_ret    <= w_tag_out.valid && !w_tag_out.is_vid;
            if (r_cpu_ret) r_cpu_rdata <= i_mem_rdata;
        end
    end

    // Wait counter restarts outside WAIT; clear beats a same-cycle maximum update.
    always_ff @(posedge i_sys_clk) begin
        if (i_act_reset) begin
            r_wait_cnt <= '0;
            r_wait_max <= '0;
        end else begin
            if (r_state != WAIT)
                r_wait_cnt <= '0;
            else if (!w_cpu_grant && r_wait_cnt != WAIT_SAT)
                r_wait_cnt <= r_wait_cnt + 1'b1;

            if (i_wait_clr)
                r_wait_max <= '0;
            else if (w_cpu_grant && r_wait_cnt > r_wait_max)
                r_wait_max <= r_wait_cnt;
        end
    end

    assign bus.vid_rvalid = r_vid_rvalid;
    assign bus.vid_rdata  = r_vid_rvalid ? i_mem_rdata : '0;
    assign bus.cpu_ack    = w_cpu_ack;
    assign bus.cpu_rdata  = r_cpu_ret ? i_mem_rdata : r_cpu_rdata;
    assign o_wait_max     = r_wait_max;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with RD_LAT=2 and a two-stage memory model.
module tb_vram_arbiter;
    import zed_vram_pkg::*;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int RD_LAT = 2;
    localparam int WAIT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              act_reset, mline_hdisp, wait_clr;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic [WAIT_W-1:0] wait_max;

    int n_checks = 0;
    int n_fail   = 0;

    vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .WAIT_W(WAIT_W)) dut (
        .i_sys_clk     (clk),
        .i_act_reset   (act_reset),
        .i_mline_hdisp (mline_hdisp),
        .bus           (bus),
        .o_mem_en      (mem_en),
        .o_mem_we      (mem_we),
        .o_mem_addr    (mem_addr),
        .o_mem_wdata   (mem_wdata),
        .i_mem_rdata   (mem_rdata),
        .o_wait_max    (wait_max),
        .i_wait_clr    (wait_clr)
    );

    function automatic logic [7:0] pat(input logic [ADDR_W-1:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    // Memory with two-cycle read latency, preloaded with pat() on the first edge.
    logic [DATA_W-1:0] mem [1<<ADDR_W];
    logic [DATA_W-1:0] r_d1, r_d2;
    bit                mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = pat(ADDR_W'(i));
            mem_loaded = 1'b1;
        end
        r_d1 <= mem[mem_addr];
        r_d2 <= r_d1;
        if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
    end
    assign mem_rdata = r_d2;

    function automatic logic [49:0] outs_vec();
        return {mem_en, mem_we, mem_addr, mem_wdata, bus.cpu_ack, bus.cpu_rdata,
                bus.vid_rvalid, bus.vid_rdata, wait_max};
    endfunction

    task automatic test_reset();
        act_reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (outs_vec() !== 50'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs_vec());
        end
        act_reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0123; bus.cpu_wdata = 8'hA5;
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b0) begin n_fail++; $display("FAIL write_not_early: got mem_en=%b expected 0", mem_en); end
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we} !== 2'b11) begin n_fail++; $display("FAIL write_strobe: got en/we=%b expected 11", {mem_en, mem_we}); end
        n_checks++;
        if (mem_addr !== 14'h0123) begin n_fail++; $display("FAIL write_addr: got %h expected 0123", mem_addr); end
        n_checks++;
        if (mem_wdata !== 8'hA5) begin n_fail++; $display("FAIL write_data: got %h expected a5", mem_wdata); end
        n_checks++;
        if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL write_ack: got %b expected 1", bus.cpu_ack); end
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_ack, mem_en} !== 2'b00) begin n_fail++; $display("FAIL write_one_shot: got ack/en=%b expected 00", {bus.cpu_ack, mem_en}); end
        n_checks++;
        if (wait_max !== 8'd0) begin n_fail++; $display("FAIL write_wait_max: got %0d expected 0", wait_max); end
    endtask

    // Idle-bus host read: grant one cycle after the request, ack three cycles after grant.
    task automatic host_read(input logic [ADDR_W-1:0] addr, input logic [7:0] exp, input string name);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = addr;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr} !== {2'b10, addr}) begin
            n_fail++; $display("FAIL %s_issue: got en/we/addr=%b/%b/%h expected 1/0/%h", name, mem_en, mem_we, mem_addr, addr);
        end
        @(negedge clk);
        n_checks++;
        if (bus.cpu_ack !== 1'b0) begin n_fail++; $display("FAIL %s_early_ack: got %b expected 0", name, bus.cpu_ack); end
        @(negedge clk);
        n_checks++;
        if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL %s_ack: got %b expected 1", name, bus.cpu_ack); end
        n_checks++;
        if (bus.cpu_rdata !== exp) begin n_fail++; $display("FAIL %s_rdata: got %h expected %h", name, bus.cpu_rdata, exp); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.cpu_ack, bus.cpu_rdata} !== {1'b0, exp}) begin
            n_fail++; $display("FAIL %s_hold: got ack=%b rdata=%h expected 0/%h", name, bus.cpu_ack, bus.cpu_rdata, exp);
        end
    endtask

    task automatic test_read();
        host_read(14'h0123, 8'hA5, "read");
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        mline_hdisp = 1'b1;
        for (int k = 0; k < 44; k++) begin
            bus.vid_req  = (k < 40);
            bus.vid_addr = ADDR_W'(k);
            @(negedge clk);
            n_checks++;
            if (mem_we !== 1'b0) begin n_fail++; $display("FAIL b2b_mem_we k=%0d: got %b expected 0", k, mem_we); end
            n_checks++;
            if (bus.vid_rvalid !== (k >= 2 && k < 42)) begin
                n_fail++; $display("FAIL b2b_rvalid k=%0d: got %b expected %b", k, bus.vid_rvalid, (k >= 2 && k < 42));
            end
            if (k >= 2 && k < 42) begin
                n_checks++;
                if (bus.vid_rdata !== pat(ADDR_W'(k - 2))) begin
                    n_fail++; $display("FAIL b2b_rdata k=%0d: got %h expected %h", k, bus.vid_rdata, pat(ADDR_W'(k - 2)));
                end
            end
            if (bus.vid_rvalid === 1'b1) pulses++;
        end
        n_checks++;
        if (pulses != 40) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 40", pulses); end
        mline_hdisp = 1'b0;
    endtask

    task automatic test_host_during_burst();
        mline_hdisp = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'd5;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            bus.vid_req  = (k < 10);
            bus.vid_addr = ADDR_W'(100 + k);
            @(negedge clk);
            if (k == 10) begin
                n_checks++;
                if ({mem_en, mem_we, mem_addr} !== {2'b10, 14'd5}) begin
                    n_fail++; $display("FAIL burst_host_issue: got en/we/addr=%b/%b/%h expected 1/0/0005", mem_en, mem_we, mem_addr);
                end
            end
            n_checks++;
            if (bus.vid_rvalid !== (k >= 2 && k < 12)) begin
                n_fail++; $display("FAIL burst_vid_rvalid k=%0d: got %b expected %b", k, bus.vid_rvalid, (k >= 2 && k < 12));
            end
            if (k >= 2 && k < 12) begin
                n_checks++;
                if (bus.vid_rdata !== pat(ADDR_W'(98 + k))) begin
                    n_fail++; $display("FAIL burst_vid_rdata k=%0d: got %h expected %h", k, bus.vid_rdata, pat(ADDR_W'(98 + k)));
                end
            end
            n_checks++;
            if (bus.cpu_ack !== (k == 12)) begin n_fail++; $display("FAIL burst_cpu_ack k=%0d: got %b expected %b", k, bus.cpu_ack, (k == 12)); end
            if (k == 12) begin
                n_checks++;
                if (bus.cpu_rdata !== 8'h5F) begin n_fail++; $display("FAIL burst_cpu_rdata: got %h expected 5f", bus.cpu_rdata); end
                bus.cpu_req = 1'b0;
            end
        end
        bus.cpu_req = 1'b0;
        n_checks++;
        if (wait_max !== 8'd10) begin n_fail++; $display("FAIL burst_wait_max: got %0d expected 10", wait_max); end
        mline_hdisp = 1'b0;
    endtask

    task automatic test_saturation();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0200; bus.cpu_wdata = 8'h3C;
        @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = ADDR_W'(i % 64);
            @(negedge clk);
        end
        n_checks++;
        if (wait_max !== 8'd10) begin n_fail++; $display("FAIL sat_no_update_while_starved: got %0d expected 10", wait_max); end
        bus.vid_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_we, mem_addr, bus.cpu_ack} !== {2'b11, 14'h0200, 1'b1}) begin
            n_fail++; $display("FAIL sat_write_issue: got en/we/addr/ack=%b/%b/%h/%b expected 1/1/0200/1", mem_en, mem_we, mem_addr, bus.cpu_ack);
        end
        n_checks++;
        if (wait_max !== 8'd255) begin n_fail++; $display("FAIL sat_wait_max: got %0d expected 255", wait_max); end
        bus.cpu_req = 1'b0;
        wait_clr = 1'b1;
        @(negedge clk);
        wait_clr = 1'b0;
        n_checks++;
        if (wait_max !== 8'd0) begin n_fail++; $display("FAIL sat_clear: got %0d expected 0", wait_max); end
    endtask

    task automatic test_clear_priority();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0201; bus.cpu_wdata = 8'h11;
        @(negedge clk);
        bus.vid_req = 1'b1; bus.vid_addr = 14'd7;
        repeat (3) @(negedge clk);
        bus.vid_req = 1'b0;
        wait_clr = 1'b1;
        @(negedge clk);
        wait_clr = 1'b0;
        n_checks++;
        if (bus.cpu_ack !== 1'b1) begin n_fail++; $display("FAIL clr_prio_ack: got %b expected 1", bus.cpu_ack); end
        n_checks++;
        if (wait_max !== 8'd0) begin n_fail++; $display("FAIL clr_prio_wait_max: got %0d expected 0", wait_max); end
        bus.cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_read();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h0123;
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (mem_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_issue: got %b expected 1", mem_en); end
        @(negedge clk);
        act_reset = 1'b1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs_vec() !== 50'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", outs_vec()); end
        n_checks++;
        if (dut.r_state !== IDLE) begin n_fail++; $display("FAIL rst_mid_state: got %0d expected IDLE", dut.r_state); end
        act_reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.cpu_ack, bus.vid_rvalid} !== 2'b00) begin
                n_fail++; $display("FAIL rst_mid_no_return i=%0d: got ack/rvalid=%b expected 00", i, {bus.cpu_ack, bus.vid_rvalid});
            end
        end
        host_read(14'h0123, 8'hA5, "read_after_reset");
    endtask

    initial begin
        act_reset = 1'b1; mline_hdisp = 1'b0; wait_clr = 1'b0;
        bus.vid_req = 1'b0; bus.vid_addr = '0;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_host_during_burst();
        test_saturation();
        test_clear_priority();
        test_reset_mid_read();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video RAM arbiter sitting between the character/font fetch path of the video controller and the host (CPU) bus port in the Nexys4 top level. Video fetches have absolute priority so the raster never misses a character or font byte; host reads and writes use the idle cycles. The block registers the shared memory port, tags each read, and routes the return data to the correct requester after a fixed memory latency. It also records the worst-case host wait time for debug readout.

## Interface
Parameters:
- ADDR_W, 14: memory address width.
- DATA_W, 8: memory data width.
- RD_LAT, 1: memory read latency in cycles, from `mem_en` to valid `mem_rdata` (1..4).
- WAIT_W, 8: width of the host wait counter.

Ports:
- sys_clk  in  1  single clock for all logic.
- act_reset  in  1  synchronous, active-high reset.
- mline_hdisp  in  1  high during active horizontal display (status qualifier only).
- vid_req  in  1  one-cycle video fetch request; may assert every cycle.
- vid_addr  in  ADDR_W  video fetch address, valid with `vid_req`.
- vid_rvalid  out  1  video read data valid.
- vid_rdata  out  DATA_W  video read data.
- cpu_req  in  1  host request; held high with its fields stable until `cpu_ack`.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  host address.
- cpu_wdata  in  DATA_W  host write data.
- cpu_ack  out  1  one-cycle completion pulse.
- cpu_rdata  out  DATA_W  host read data, valid with `cpu_ack` on reads.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- wait_max  out  WAIT_W  largest host wait in cycles since clear; saturates.
- wait_clr  in  1  clears `wait_max` to 0.

## Operation
- Grant each cycle: `vid_req` wins; otherwise a pending, un-issued host request wins; otherwise idle.
- Host FSM states:
  - IDLE: `cpu_req` seen and not yet issued → WAIT.
  - WAIT: granted → write goes to ACK; read goes to RDPEND.
  - RDPEND: tagged return arrives → ACK.
  - ACK: `cpu_ack` high for one cycle → IDLE.
- A new host request is sampled no earlier than the cycle after ACK. Only one host transaction is outstanding at a time.
- Read tag pipeline: a shift register of depth RD_LAT carries {valid, is_vid}. On return:
  - is_vid → `vid_rvalid`=1, `vid_rdata`=`mem_rdata`.
  - host → latch `cpu_rdata`.
- Video reads may be issued back-to-back every cycle; returns are in order.
- Wait counter:
  - Counts cycles spent in WAIT.
  - On grant, `wait_max` ← max(`wait_max`, count).
  - Counter saturates at 2^WAIT_W−1.
  - `wait_clr` takes priority over an update in the same cycle.
- `mline_hdisp` does not change priority. A host request arriving while `mline_hdisp`=1 is simply expected to wait longer.

## Timing
- Grant is decided from inputs in cycle N; `mem_*` are registered and driven in cycle N+1.
- Video: `vid_req` in cycle N → `vid_rvalid` in cycle N+1+RD_LAT.
- Host write: grant in N → `mem_en`/`mem_we` in N+1, `cpu_ack` in N+1.
- Host read: grant in N → `mem_en` in N+1, `cpu_ack` and `cpu_rdata` in N+1+RD_LAT.
- `mem_we`=0 on every video access. `mem_en`=0 on idle cycles; `mem_addr` and `mem_wdata` then hold their last values.
- Simultaneous `vid_req` and a host grant candidate: video issues and the host stays in WAIT.
- Continuous `vid_req` starves the host indefinitely. This is legal, and `wait_max` saturates.
- Reset, including mid-transaction:
  - All outputs go to 0; FSM goes to IDLE; tag pipeline is flushed; wait counter and `wait_max` go to 0.
  - An in-flight read returns no valid or ack.

## Structure
- `zed_vram_pkg`: host FSM state enum (IDLE, WAIT, RDPEND, ACK) and a tag struct {valid, is_vid}.
- One sub-module, `rd_tag_pipe`: parameterised RD_LAT-deep shift register of tags, with synchronous flush on reset.

## Test plan
- Single host write, addr 0x0123 data 0xA5, no video → `mem_en`=`mem_we`=1 one cycle after grant, `cpu_ack` in the same cycle, `wait_max`=0.
- Host read of 0x0123 with RD_LAT=2 and a memory model → `cpu_ack` 3 cycles after grant, `cpu_rdata`=0xA5.
- 40 back-to-back `vid_req` (addresses 0..39) with `mline_hdisp`=1 → 40 `vid_rvalid` pulses in order with the correct data, no gaps, `mem_we` never asserted.
- Host read pending during a 10-cycle video burst → host issues on the first idle cycle, `wait_max`=10, video data unaffected.
- Continuous video for 300 cycles with host pending, WAIT_W=8 → `wait_max`=255 (saturated); `wait_clr` then returns it to 0.
- `act_reset` asserted one cycle after a host read issues → no `cpu_ack`, all outputs 0 next cycle, FSM IDLE; a subsequent read completes normally.
